// File: rtl/cram_access_arbiter.sv
// Round-robin arbiter sharing one CRAM load/store port among NUM_REQ requesters,
// with load-owner tracking. Optional grant locking is enabled by CRAM_ARB_LOCK_EN.
module cram_access_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_ADDR = 10,
  parameter int WIDTH_DATA = 32,
  parameter int LD_LATENCY = 1,
  parameter int MAX_LOCK   = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            I_Req,
  input  logic [NUM_REQ-1:0]            I_We,
  input  logic [NUM_REQ*2-1:0]          I_Mode,
  input  logic [NUM_REQ*WIDTH_ADDR-1:0] I_Addr,
  input  logic [NUM_REQ*WIDTH_DATA-1:0] I_WData,
  input  logic [NUM_REQ-1:0]            I_Lock,
  output logic [NUM_REQ-1:0]            O_Gnt,
  output logic [NUM_REQ-1:0]            O_RValid,
  output logic [WIDTH_DATA-1:0]         O_RData,
  output logic [NUM_REQ-1:0]            O_Err,
  output logic                          O_Ld_Req,
  output logic [1:0]                    O_Ld_Mode,
  output logic [WIDTH_ADDR-1:0]         O_Ld_Addr,
  input  logic                          I_Ld_Valid,
  input  logic [WIDTH_DATA-1:0]         I_Ld_Data,
  output logic                          O_St_Req,
  output logic [1:0]                    O_St_Mode,
  output logic [WIDTH_ADDR-1:0]         O_St_Addr,
  output logic [WIDTH_DATA-1:0]         O_St_Data,
  output logic                          O_Fault
);

  localparam int IDW = $clog2(NUM_REQ);

  function automatic logic [IDW-1:0] wrap_id(input int v);
    return IDW'((v >= NUM_REQ) ? v - NUM_REQ : v);
  endfunction

  logic [IDW-1:0]        rr_ptr;
  logic                  gnt_v;
  logic [IDW-1:0]        gnt_id;
  logic                  sel_we;
  logic [1:0]            sel_mode;
  logic [WIDTH_ADDR-1:0] sel_addr;
  logic [WIDTH_DATA-1:0] sel_wdata;
  logic                  sel_bad_mode;
  logic [IDW-1:0]        ld_id_q;

  // Owner pipe: stage 0 lines up with the cycle after O_Ld_Req, the head with I_Ld_Valid.
  logic                  pipe_v  [LD_LATENCY];
  logic [IDW-1:0]        pipe_id [LD_LATENCY];
  logic                  head_v;
  logic [IDW-1:0]        head_id;
  logic                  ret_ok;

`ifdef CRAM_ARB_LOCK_EN
  localparam int LCW = $clog2(MAX_LOCK + 1);
  logic           last_v;
  logic [IDW-1:0] last_id;
  logic [LCW-1:0] lock_cnt;
  logic           lock_ok;

  // A saturated counter blocks re-locking until another requester or an idle cycle resets it.
  assign lock_ok = last_v && I_Lock[last_id] && I_Req[last_id] &&
                   (int'(lock_cnt) < MAX_LOCK);
`else
  localparam int unused_max_lock = MAX_LOCK;
  logic          unused_lock;
  assign unused_lock = ^I_Lock;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_v && I_Req[wrap_id(int'(rr_ptr) + k)]) begin
        gnt_v  = 1'b1;
        gnt_id = wrap_id(int'(rr_ptr) + k);
      end
    end
`ifdef CRAM_ARB_LOCK_EN
    if (lock_ok) begin
      gnt_v  = 1'b1;
      gnt_id = last_id;
    end
`endif
    if (reset) gnt_v = 1'b0;
  end

  assign sel_we       = I_We[gnt_id];
  assign sel_mode     = I_Mode[gnt_id*2 +: 2];
  assign sel_addr     = I_Addr[gnt_id*WIDTH_ADDR +: WIDTH_ADDR];
  assign sel_wdata    = I_WData[gnt_id*WIDTH_DATA +: WIDTH_DATA];
  assign sel_bad_mode = (sel_mode == 2'd3);

  assign O_Gnt = gnt_v ? (NUM_REQ'(1) << gnt_id) : '0;
  assign O_Err = (gnt_v && sel_bad_mode) ? O_Gnt : '0;

  assign head_v   = pipe_v[LD_LATENCY-1];
  assign head_id  = pipe_id[LD_LATENCY-1];
  assign ret_ok   = head_v && I_Ld_Valid && !reset;
  assign O_RValid = ret_ok ? (NUM_REQ'(1) << head_id) : '0;
  assign O_RData  = ret_ok ? I_Ld_Data : '0;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr    <= '0;
      O_Ld_Req  <= 1'b0;
      O_Ld_Mode <= '0;
      O_Ld_Addr <= '0;
      ld_id_q   <= '0;
      O_St_Req  <= 1'b0;
      O_St_Mode <= '0;
      O_St_Addr <= '0;
      O_St_Data <= '0;
      O_Fault   <= 1'b0;
      // NOTE: the owner pipe is a few flops, not a RAM, so it is cleared to drop in-flight loads.
      for (int s = 0; s < LD_LATENCY; s++) begin
        pipe_v[s]  <= 1'b0;
        pipe_id[s] <= '0;
      end
`ifdef CRAM_ARB_LOCK_EN
      last_v   <= 1'b0;
      last_id  <= '0;
      lock_cnt <= '0;
`endif
    end else begin
      O_Ld_Req  <= gnt_v && !sel_we && !sel_bad_mode;
      O_Ld_Mode <= (gnt_v && !sel_we && !sel_bad_mode) ? sel_mode : '0;
      O_Ld_Addr <= (gnt_v && !sel_we && !sel_bad_mode) ? sel_addr : '0;
      ld_id_q   <= gnt_id;
      O_St_Req  <= gnt_v && sel_we && !sel_bad_mode;
      O_St_Mode <= (gnt_v && sel_we && !sel_bad_mode) ? sel_mode : '0;
      O_St_Addr <= (gnt_v && sel_we && !sel_bad_mode) ? sel_addr : '0;
      O_St_Data <= (gnt_v && sel_we && !sel_bad_mode) ? sel_wdata : '0;

      pipe_v[0]  <= O_Ld_Req;
      pipe_id[0] <= ld_id_q;
      for (int s = 1; s < LD_LATENCY; s++) begin
        pipe_v[s]  <= pipe_v[s-1];
        pipe_id[s] <= pipe_id[s-1];
      end

      if (head_v != I_Ld_Valid) O_Fault <= 1'b1;
      if (gnt_v) rr_ptr <= wrap_id(int'(gnt_id) + 1);

`ifdef CRAM_ARB_LOCK_EN
      last_v  <= gnt_v;
      last_id <= gnt_id;
      if (!gnt_v)
        lock_cnt <= '0;
      else if (last_v && gnt_id == last_id)
        lock_cnt <= (int'(lock_cnt) < MAX_LOCK) ? lock_cnt + 1'b1 : lock_cnt;
      else
        lock_cnt <= LCW'(1);
`endif
    end
  end

endmodule
